// File: rtl/regfile_pkg.sv
// Shared constants for the parametrised register file with pending scoreboard.
// Holds default geometry, the hardwired-zero (XZR) index and the address-width rule.
package regfile_pkg;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_RPORTS = 2;
    localparam int XZR        = 31;

    // Address width for a power-of-two register count (at least one bit).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_AW = addr_width(DEF_DEPTH);

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Issue/writeback bus of the register file scoreboard.
// master = issue/writeback side, slave = register file.
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int RPORTS = DEF_RPORTS
) ();
    localparam int AW = addr_width(DEPTH);

    logic [RPORTS*AW-1:0]    SA;
    logic [RPORTS*WIDTH-1:0] A;
    logic [RPORTS-1:0]       A_rdy;
    logic [WIDTH-1:0]        D;
    logic [AW-1:0]           DA;
    logic                    W;
    logic                    RSV;
    logic [AW-1:0]           RA;
    logic                    rsv_ok;
    logic [DEPTH-1:0]        busy;
    logic [AW:0]             pend_cnt;

    modport master (
        output SA, D, DA, W, RSV, RA,
        input  A, A_rdy, rsv_ok, busy, pend_cnt
    );

    modport slave (
        input  SA, D, DA, W, RSV, RA,
        output A, A_rdy, rsv_ok, busy, pend_cnt
    );
endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: array mux, busy lookup, zero-register masking.
// With REGFILE_BYPASS_EN defined, a same-cycle write to the addressed register
// is forwarded to the port and reported ready.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = addr_width(DEPTH),
    parameter int ZERO_REG = XZR
) (
`ifdef REGFILE_BYPASS_EN
    input  logic                        wr_en_i,
    input  logic [AW-1:0]               wr_addr_i,
    input  logic [WIDTH-1:0]            wr_data_i,
`endif
    input  logic [AW-1:0]               sa_i,
    input  logic [DEPTH-1:0][WIDTH-1:0] regs_i,
    input  logic [DEPTH-1:0]            busy_i,
    output logic [WIDTH-1:0]            data_o,
    output logic                        rdy_o
);
    localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

    // Select stored data and ready flag; bypass first, zero register last so it always wins.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        data_o = regs_i[sa_i];
        rdy_o  = ~busy_i[sa_i];
`ifdef REGFILE_BYPASS_EN
        if (wr_en_i && (wr_addr_i == sa_i) && (wr_addr_i != ZA)) begin
            data_o = wr_data_i;
            rdy_o  = 1'b1;
        end
`endif
        if (sa_i == ZA) begin
            data_o = '0;
            rdy_o  = 1'b1;
        end
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with hardwired zero register and per-register pending scoreboard.
// Issue reserves a destination (busy bit set), writeback fills it and clears the bit.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int RPORTS   = DEF_RPORTS,
    parameter int ZERO_REG = XZR
) (
    input  logic                 clock,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);
    localparam int            AW  = addr_width(DEPTH);
    localparam logic [AW-1:0] ZA  = AW'(ZERO_REG);
    localparam logic [AW:0]   ONE = (AW+1)'(1);

    logic [DEPTH-1:0][WIDTH-1:0] regs_q;
    logic [DEPTH-1:0]            busy_q, busy_d;
    logic [AW:0]                 cnt_q, cnt_d;
    logic                        wr_eff, rsv_grant, rsv_set, cnt_inc, cnt_dec;

    logic [RPORTS-1:0][WIDTH-1:0] rd_data;
    logic [RPORTS-1:0]            rd_rdy;

    assign wr_eff    = bus.W && (bus.DA != ZA);
    assign rsv_grant = bus.RSV && (~busy_q[bus.RA] || (bus.RA == ZA));
    assign rsv_set   = rsv_grant && (bus.RA != ZA);

    // Next busy bitmap and pending count; the reserve is applied after the write so it wins on DA==RA.
    always_comb begin
        busy_d = busy_q;
        if (wr_eff)  busy_d[bus.DA] = 1'b0;
        if (rsv_set) busy_d[bus.RA] = 1'b1;

        cnt_inc = rsv_set;
        cnt_dec = wr_eff && busy_q[bus.DA] && !(rsv_set && (bus.RA == bus.DA));
        cnt_d   = cnt_q;
        if (cnt_inc && !cnt_dec)      cnt_d = cnt_q + ONE;
        else if (cnt_dec && !cnt_inc) cnt_d = cnt_q - ONE;
    end

    // Scoreboard state: busy bitmap and its population count.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Register array; XZR is never written so it stays at its reset value.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: the array is reset on purpose: every register must read 0 during and after reset.
        if (reset) begin
            regs_q <= '0;
        end else if (wr_eff) begin
            regs_q[bus.DA] <= bus.D;
        end
    end

    for (genvar i = 0; i < RPORTS; i++) begin : g_rd
        regfile_read_port #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
`ifdef REGFILE_BYPASS_EN
            .wr_en_i   (bus.W),
            .wr_addr_i (bus.DA),
            .wr_data_i (bus.D),
`endif
            .sa_i      (bus.SA[i*AW +: AW]),
            .regs_i    (regs_q),
            .busy_i    (busy_q),
            .data_o    (rd_data[i]),
            .rdy_o     (rd_rdy[i])
        );
    end

    assign bus.A        = rd_data;
    assign bus.A_rdy    = rd_rdy;
    assign bus.rsv_ok   = rsv_grant;
    assign bus.busy     = busy_q;
    assign bus.pend_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench for regfile_scoreboard (default 64x32, 2 read ports).
// Stimulus pushes expected values into a queue; the monitor compares on each observation strobe.
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    typedef enum int {F_A0, F_A1, F_RDY, F_BUSY, F_CNT, F_OK} fld_e;
    typedef struct {
        string       name;
        fld_e        fld;
        logic [63:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];
    event obs_ev;

    regfile_scoreboard_if #(.WIDTH(64), .DEPTH(32), .RPORTS(2)) bus ();

    regfile_scoreboard dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input fld_e fld, input logic [63:0] v);
        exp_t e;
        e.name = name;
        e.fld  = fld;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    // Strobe the monitor well away from any clock edge (3 ns after the caller's point).
    task automatic observe();
        #3;
        -> obs_ev;
        #1;
    endtask

    task automatic set_sa(input int p0, input int p1);
        bus.SA = {5'(p1), 5'(p0)};
    endtask

    // Monitor: pops every pending expectation at each strobe and compares against live outputs.
    initial begin
        forever begin
            @(obs_ev);
            while (sb_q.size() > 0) begin
                exp_t        e;
                logic [63:0] act;
                e = sb_q.pop_front();
                case (e.fld)
                    F_A0:    act = bus.A[63:0];
                    F_A1:    act = bus.A[127:64];
                    F_RDY:   act = {62'b0, bus.A_rdy};
                    F_BUSY:  act = {32'b0, bus.busy};
                    F_CNT:   act = {58'b0, bus.pend_cnt};
                    default: act = {63'b0, bus.rsv_ok};
                endcase
                n_checks++;
                if (act === e.exp) n_pass++;
                else $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        // Reset held with W and RSV active: nothing may land.
        rst = 1'b1;
        bus.W = 1'b1;  bus.DA = 5'd5; bus.D = 64'hFF;
        bus.RSV = 1'b1; bus.RA = 5'd7;
        set_sa(5, 7);
        repeat (3) step();
        expect_val("rst_a0",   F_A0,   64'h0);
        expect_val("rst_a1",   F_A1,   64'h0);
        expect_val("rst_rdy",  F_RDY,  64'h3);
        expect_val("rst_busy", F_BUSY, 64'h0);
        expect_val("rst_cnt",  F_CNT,  64'h0);
        expect_val("rst_ok",   F_OK,   64'h1);
        observe();
        bus.W = 1'b0; bus.RSV = 1'b0;
        rst = 1'b0;
        step();
        expect_val("post_rst_busy", F_BUSY, 64'h0);
        expect_val("post_rst_a0",   F_A0,   64'h0);
        observe();

        // Write R5, read R5 and XZR.
        bus.W = 1'b1; bus.DA = 5'd5; bus.D = 64'hDEADBEEF_0BADF00D;
        set_sa(5, 31);
        step();
        bus.W = 1'b0;
        expect_val("wr_r5_a0", F_A0,  64'hDEADBEEF_0BADF00D);
        expect_val("xzr_a1",   F_A1,  64'h0);
        expect_val("wr_rdy",   F_RDY, 64'h3);
        observe();

        // Write to XZR is discarded.
        bus.W = 1'b1; bus.DA = 5'd31; bus.D = 64'h1;
        step();
        bus.W = 1'b0;
        expect_val("xzr_wr_a1",   F_A1,   64'h0);
        expect_val("xzr_wr_rdy",  F_RDY,  64'h3);
        expect_val("xzr_wr_busy", F_BUSY, 64'h0);
        observe();

        // Reserve R7.
        bus.RSV = 1'b1; bus.RA = 5'd7;
        expect_val("rsv7_ok", F_OK, 64'h1);
        observe();
        step();
        bus.RSV = 1'b0;
        set_sa(7, 31);
        expect_val("rsv7_busy", F_BUSY, 64'h80);
        expect_val("rsv7_cnt",  F_CNT,  64'h1);
        expect_val("rsv7_rdy",  F_RDY,  64'h2);
        observe();

        // Second reserve of R7 is denied and changes nothing.
        bus.RSV = 1'b1; bus.RA = 5'd7;
        expect_val("rsv7_again_ok", F_OK, 64'h0);
        observe();
        step();
        bus.RSV = 1'b0;
        expect_val("rsv7_again_busy", F_BUSY, 64'h80);
        expect_val("rsv7_again_cnt",  F_CNT,  64'h1);
        observe();

        // Writeback to R7 clears the reservation.
        bus.W = 1'b1; bus.DA = 5'd7; bus.D = 64'h1234;
        step();
        bus.W = 1'b0;
        expect_val("wb7_busy", F_BUSY, 64'h0);
        expect_val("wb7_cnt",  F_CNT,  64'h0);
        expect_val("wb7_a0",   F_A0,   64'h1234);
        expect_val("wb7_rdy",  F_RDY,  64'h3);
        observe();

        // Same edge write and reserve of idle R9: data lands, reserve wins.
        bus.W = 1'b1; bus.DA = 5'd9; bus.D = 64'hAA;
        bus.RSV = 1'b1; bus.RA = 5'd9;
        expect_val("wr_rsv9_ok", F_OK, 64'h1);
        observe();
        step();
        bus.W = 1'b0; bus.RSV = 1'b0;
        set_sa(9, 31);
        expect_val("wr_rsv9_a0",   F_A0,   64'hAA);
        expect_val("wr_rsv9_busy", F_BUSY, 64'h200);
        expect_val("wr_rsv9_cnt",  F_CNT,  64'h1);
        expect_val("wr_rsv9_rdy",  F_RDY,  64'h2);
        observe();

        // Reserve on XZR: granted, no effect.
        bus.RSV = 1'b1; bus.RA = 5'd31;
        expect_val("rsv_xzr_ok", F_OK, 64'h1);
        observe();
        step();
        bus.RSV = 1'b0;
        expect_val("rsv_xzr_busy", F_BUSY, 64'h200);
        expect_val("rsv_xzr_cnt",  F_CNT,  64'h1);
        observe();

        // Write clears R9 while reserving R11 on the same edge: count unchanged.
        bus.W = 1'b1; bus.DA = 5'd9; bus.D = 64'hBB;
        bus.RSV = 1'b1; bus.RA = 5'd11;
        step();
        bus.W = 1'b0; bus.RSV = 1'b0;
        set_sa(9, 11);
        expect_val("swap_busy", F_BUSY, 64'h800);
        expect_val("swap_cnt",  F_CNT,  64'h1);
        expect_val("swap_a0",   F_A0,   64'hBB);
        expect_val("swap_rdy",  F_RDY,  64'h1);
        observe();

        // Write to R3 while reading it in the same cycle.
        set_sa(3, 31);
        bus.W = 1'b1; bus.DA = 5'd3; bus.D = 64'h55;
`ifdef REGFILE_BYPASS_EN
        expect_val("byp_same_a0",  F_A0,  64'h55);
`else
        expect_val("byp_same_a0",  F_A0,  64'h0);
`endif
        expect_val("byp_same_rdy", F_RDY, 64'h3);
        observe();
        step();
        bus.W = 1'b0;
        expect_val("byp_next_a0", F_A0, 64'h55);
        observe();

        // Clear R11, then reserve R2 and R4.
        bus.W = 1'b1; bus.DA = 5'd11; bus.D = 64'h0;
        step();
        bus.W = 1'b0;
        bus.RSV = 1'b1; bus.RA = 5'd2;
        step();
        bus.RA = 5'd4;
        step();
        bus.RSV = 1'b0;
        set_sa(2, 4);
        expect_val("pre_arst_busy", F_BUSY, 64'h14);
        expect_val("pre_arst_cnt",  F_CNT,  64'h2);
        expect_val("pre_arst_rdy",  F_RDY,  64'h0);
        observe();

        // Asynchronous reset mid-cycle: clears with no clock edge in between.
        #1;
        rst = 1'b1;
        expect_val("arst_busy", F_BUSY, 64'h0);
        expect_val("arst_cnt",  F_CNT,  64'h0);
        expect_val("arst_rdy",  F_RDY,  64'h3);
        observe();
        set_sa(5, 3);
        expect_val("arst_a0", F_A0, 64'h0);
        expect_val("arst_a1", F_A1, 64'h0);
        observe();
        step();
        rst = 1'b0;
        step();
        expect_val("arst_rel_cnt", F_CNT, 64'h0);
        observe();

        if (sb_q.size() != 0) begin
            $display("FAIL drain: got %0d unchecked expectations, expected 0", sb_q.size());
            n_checks += sb_q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
